// File: rtl/keccak_pkg.sv
// Shared constants, FSM encoding and lane helper for the Keccak-1600 absorb front end.
package keccak_pkg;

    localparam int STATE_W        = 1600;
    localparam int LANE_W         = 64;
    localparam int RATE_LANES_DFLT = 17;

    localparam logic [7:0] KECCAK_PAD_BYTE      = 8'h01;
    localparam logic [7:0] KECCAK_LAST_PAD_BYTE = 8'h80;

    typedef logic [2:0] absorb_st_t;

    localparam absorb_st_t ST_ABSORB    = 3'd0;
    localparam absorb_st_t ST_PAD       = 3'd1;
    localparam absorb_st_t ST_PERM_REQ  = 3'd2;
    localparam absorb_st_t ST_PERM_WAIT = 3'd3;
    localparam absorb_st_t ST_DONE      = 3'd4;

    // Lane index of (x,y) inside the flat state vector
    function automatic int idx(input int x, input int y);
        return 5 * y + x;
    endfunction

endpackage

// File: rtl/keccak_pad_mask.sv
// pad10*1 XOR mask: PAD_BYTE at byte pad_pos, LAST_PAD_BYTE at the last rate byte.
module keccak_pad_mask
    import keccak_pkg::*;
#(
    parameter int         RATE_LANES    = RATE_LANES_DFLT,
    parameter logic [7:0] PAD_BYTE      = KECCAK_PAD_BYTE,
    parameter logic [7:0] LAST_PAD_BYTE = KECCAK_LAST_PAD_BYTE
) (
    input  logic [7:0]         pad_pos,
    output logic [STATE_W-1:0] mask
);

    localparam int RATE_BYTES = RATE_LANES * 8;

    // Byte b of the state lives at bits [8b+7:8b]; both pad bytes coincide when pad_pos is the last byte
    always_comb begin
        mask = '0;
        for (int b = 0; b < RATE_BYTES; b++) begin
            mask[8*b +: 8] = ((pad_pos == 8'(b)) ? PAD_BYTE : 8'h00)
                           ^ ((b == RATE_BYTES - 1) ? LAST_PAD_BYTE : 8'h00);
        end
    end

endmodule

// File: rtl/keccak_absorb.sv
// Keccak-1600 absorb stage: lane stream in, padded blocks out to the permutation core.
// Optional block counter output o_blk_cnt enabled by KECCAK_ABSORB_BLKCNT_EN.
module keccak_absorb
    import keccak_pkg::*;
#(
    parameter int         RATE_LANES    = RATE_LANES_DFLT,
    parameter logic [7:0] PAD_BYTE      = KECCAK_PAD_BYTE,
    parameter logic [7:0] LAST_PAD_BYTE = KECCAK_LAST_PAD_BYTE
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [LANE_W-1:0]  i_word,
    input  logic [3:0]         i_word_bytes,
    input  logic               i_word_last,
    input  logic               i_word_valid,
    output logic               o_word_ready,
    output logic [STATE_W-1:0] o_perm_state,
    output logic               o_perm_valid,
    input  logic               i_perm_ready,
    input  logic [STATE_W-1:0] i_perm_state,
    input  logic               i_perm_done,
    output logic [STATE_W-1:0] o_state,
    output logic               o_state_valid,
`ifdef KECCAK_ABSORB_BLKCNT_EN
    output logic [7:0]         o_blk_cnt,
`endif
    input  logic               i_state_ready
);

    localparam int         RATE_BYTES   = RATE_LANES * 8;
    localparam logic [7:0] RATE_BYTES_B = 8'(RATE_BYTES);
    localparam logic [4:0] LAST_LANE    = 5'(RATE_LANES - 1);

    absorb_st_t         fsm_q, fsm_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic [4:0]         lane_cnt_q, lane_cnt_d;
    logic [7:0]         pad_pos_q, pad_pos_d;
    logic               final_q, final_d;
    logic               pend_q, pend_d;
    logic               word_ready_q, perm_valid_q, state_valid_q;
    logic [STATE_W-1:0] pad_mask_s;
    logic [3:0]         bytes_s;
    logic [LANE_W-1:0]  word_mask_s;
    logic               word_fire_s;

    keccak_pad_mask #(
        .RATE_LANES    (RATE_LANES),
        .PAD_BYTE      (PAD_BYTE),
        .LAST_PAD_BYTE (LAST_PAD_BYTE)
    ) u_pad_mask (
        .pad_pos (pad_pos_q),
        .mask    (pad_mask_s)
    );

    // Clamp the byte count and build the keep-mask for the incoming lane
    always_comb begin
        bytes_s = (i_word_bytes > 4'd8) ? 4'd8 : i_word_bytes;
        for (int k = 0; k < 8; k++) begin
            word_mask_s[8*k +: 8] = (4'(k) < bytes_s) ? 8'hFF : 8'h00;
        end
    end

    assign word_fire_s = i_word_valid & word_ready_q;

    // Absorb FSM next-state and state datapath
    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        pad_pos_d  = pad_pos_q;
        final_d    = final_q;
        pend_d     = pend_q;
        case (fsm_q)
            ST_ABSORB: begin
                if (word_fire_s) begin
                    state_d[LANE_W*lane_cnt_q +: LANE_W] = state_q[LANE_W*lane_cnt_q +: LANE_W]
                                                         ^ (i_word & word_mask_s);
                    // last wins over a full block: a 136-byte end pads into an extra block
                    if (i_word_last) begin
                        pad_pos_d = {lane_cnt_q, 3'b000} + {4'd0, bytes_s};
                        fsm_d     = ST_PAD;
                    end else if (lane_cnt_q == LAST_LANE) begin
                        lane_cnt_d = 5'd0;
                        fsm_d      = ST_PERM_REQ;
                    end else begin
                        lane_cnt_d = lane_cnt_q + 5'd1;
                    end
                end else begin
                    fsm_d = ST_ABSORB;
                end
            end
            ST_PAD: begin
                if (pad_pos_q == RATE_BYTES_B) begin
                    pad_pos_d = 8'd0;
                    pend_d    = 1'b1;
                    final_d   = 1'b0;
                end else begin
                    state_d = state_q ^ pad_mask_s;
                    final_d = 1'b1;
                end
                fsm_d = ST_PERM_REQ;
            end
            ST_PERM_REQ: begin
                if (i_perm_ready) begin
                    fsm_d = ST_PERM_WAIT;
                end else begin
                    fsm_d = ST_PERM_REQ;
                end
            end
            ST_PERM_WAIT: begin
                if (i_perm_done) begin
                    state_d    = i_perm_state;
                    lane_cnt_d = 5'd0;
                    if (final_q) begin
                        fsm_d = ST_DONE;
                    end else if (pend_q) begin
                        pend_d = 1'b0;
                        fsm_d  = ST_PAD;
                    end else begin
                        fsm_d = ST_ABSORB;
                    end
                end else begin
                    fsm_d = ST_PERM_WAIT;
                end
            end
            ST_DONE: begin
                if (i_state_ready) begin
                    state_d    = '0;
                    lane_cnt_d = 5'd0;
                    pad_pos_d  = 8'd0;
                    final_d    = 1'b0;
                    pend_d     = 1'b0;
                    fsm_d      = ST_ABSORB;
                end else begin
                    fsm_d = ST_DONE;
                end
            end
            default: begin
                state_d    = '0;
                lane_cnt_d = 5'd0;
                pad_pos_d  = 8'd0;
                final_d    = 1'b0;
                pend_d     = 1'b0;
                fsm_d      = ST_ABSORB;
            end
        endcase
    end

    // State, control flops and registered handshake outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fsm_q         <= ST_ABSORB;
            state_q       <= '0;
            lane_cnt_q    <= 5'd0;
            pad_pos_q     <= 8'd0;
            final_q       <= 1'b0;
            pend_q        <= 1'b0;
            word_ready_q  <= 1'b0;
            perm_valid_q  <= 1'b0;
            state_valid_q <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            state_q       <= state_d;
            lane_cnt_q    <= lane_cnt_d;
            pad_pos_q     <= pad_pos_d;
            final_q       <= final_d;
            pend_q        <= pend_d;
            word_ready_q  <= (fsm_d == ST_ABSORB);
            perm_valid_q  <= (fsm_d == ST_PERM_REQ);
            state_valid_q <= (fsm_d == ST_DONE);
        end
    end

    assign o_word_ready  = word_ready_q;
    assign o_perm_valid  = perm_valid_q;
    assign o_state_valid = state_valid_q;
    assign o_perm_state  = state_q;
    assign o_state       = state_q;

`ifdef KECCAK_ABSORB_BLKCNT_EN
    logic [7:0] blk_cnt_q, blk_cnt_d;

    // Saturating count of blocks issued for the current message
    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if ((fsm_q == ST_DONE) && i_state_ready) begin
            blk_cnt_d = 8'd0;
        end else if ((fsm_q == ST_PERM_REQ) && i_perm_ready && (blk_cnt_q != 8'hFF)) begin
            blk_cnt_d = blk_cnt_q + 8'd1;
        end else begin
            blk_cnt_d = blk_cnt_q;
        end
    end

    // Block counter register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            blk_cnt_q <= 8'd0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign o_blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_keccak_absorb.sv
// Self-checking bench for keccak_absorb: padded-message reference model plus a stand-in permutation.
module tb_keccak_absorb;

    localparam int RB = 136;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [63:0]    word;
    logic [3:0]     word_bytes;
    logic           word_last, word_valid, word_ready;
    logic [1599:0]  perm_state_o, perm_state_i, state_o;
    logic           perm_valid, perm_ready, perm_done;
    logic           state_valid, state_ready;
`ifdef KECCAK_ABSORB_BLKCNT_EN
    logic [7:0]     blk_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    keccak_absorb dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_word        (word),
        .i_word_bytes  (word_bytes),
        .i_word_last   (word_last),
        .i_word_valid  (word_valid),
        .o_word_ready  (word_ready),
        .o_perm_state  (perm_state_o),
        .o_perm_valid  (perm_valid),
        .i_perm_ready  (perm_ready),
        .i_perm_state  (perm_state_i),
        .i_perm_done   (perm_done),
        .o_state       (state_o),
        .o_state_valid (state_valid),
`ifdef KECCAK_ABSORB_BLKCNT_EN
        .o_blk_cnt     (blk_cnt),
`endif
        .i_state_ready (state_ready)
    );

    typedef struct {
        int         len;
        int         nblk;
        int         pos;
        logic [7:0] vpos;
        logic [7:0] v135;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [1599:0] act, input logic [1599:0] exp);
        int l;
        l = 0;
        checks++;
        if (act !== exp) begin
            errors++;
            for (int i = 24; i >= 0; i--) if (act[64*i +: 64] !== exp[64*i +: 64]) l = i;
            $display("FAIL %s lane %0d actual %h required %h", name, l, act[64*l +: 64], exp[64*l +: 64]);
        end
    endtask

    task automatic chk32(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    // Stand-in permutation: any bijective scramble serves to prove the returned state is used
    function automatic logic [1599:0] perm_f(input logic [1599:0] s);
        return {s[1598:0], s[1599]} ^ {25{64'h9E37_79B9_7F4A_7C15}};
    endfunction

    function automatic logic [1599:0] get_blk(input byte unsigned q[$], input int k);
        logic [1599:0] r;
        r = '0;
        for (int b = 0; b < RB; b++) if (k * RB + b < q.size()) r[8*b +: 8] = q[k*RB + b];
        return r;
    endfunction

    task automatic run_msg(input int len, input bit rnd, input int pr_delay, input int st_delay,
                           input bit abort, input int exp_nblk, output logic [1599:0] last_delta);
        byte unsigned  p[$];
        logic [63:0]   wd[$];
        logic [3:0]    wb[$];
        bit            wl[$];
        int            nblk, nw, wi, blk, cnt, pr_cd, done_cd, st_cd, last_acc, done_cyc;
        bit            seen_pv, seen_sv, lat_pend, finished;
        logic [1599:0] s_model, exp_blk;
        nblk = len / RB + 1;
        wi = 0; blk = 0; cnt = 0; pr_cd = 0; done_cd = -1; st_cd = 0; last_acc = 0; done_cyc = 0;
        seen_pv = 0; seen_sv = 0; lat_pend = 0; finished = 0;
        s_model = '0; exp_blk = '0; last_delta = '0;
        for (int i = 0; i < nblk * RB; i++) p.push_back(8'h00);
        for (int i = 0; i < len; i++) p[i] = rnd ? 8'($urandom) : 8'h00;
        nw = (len + 7) / 8;
        if (nw == 0) nw = 1;
        for (int w = 0; w < nw; w++) begin
            logic [63:0] d;
            int nb;
            nb = (len - 8 * w >= 8) ? 8 : len - 8 * w;
            d = {$urandom, $urandom};
            for (int k = 0; k < nb; k++) d[8*k +: 8] = p[8*w + k];
            wd.push_back(d);
            wb.push_back((nb == 8 && rnd && $urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'(nb));
            wl.push_back(w == nw - 1);
        end
        p[len] = p[len] ^ 8'h01;
        p[nblk*RB - 1] = p[nblk*RB - 1] ^ 8'h80;

        while (!finished) begin
            @(negedge clk);
            cnt++;
            word_valid = 1'b0; perm_ready = 1'b0; perm_done = 1'b0; state_ready = 1'b0;
            perm_state_i = {50{$urandom}};
            if (cnt > 3000) begin
                checks++; errors++;
                $display("FAIL timeout len %0d after %0d cycles", len, cnt);
                break;
            end
            if (perm_valid || state_valid) chk32("word_ready_low", int'(word_ready), 0);
            if (seen_pv) chk32("perm_valid_hold", int'(perm_valid), 1);
            if (seen_sv) chk32("state_valid_hold", int'(state_valid), 1);
            if (done_cd >= 0) begin
                if (abort) begin
                    rst_n = 1'b0;
                    finished = 1;
                end else if (done_cd == 0) begin
                    perm_done = 1'b1;
                    s_model = perm_f(exp_blk);
                    perm_state_i = s_model;
                    done_cyc = cnt;
                    done_cd = -1;
                end else begin
                    done_cd--;
                end
            end
            if (!finished && perm_valid) begin
                if (!seen_pv) begin
                    seen_pv = 1;
                    exp_blk = s_model ^ get_blk(p, blk);
                    if (blk == nblk - 1) last_delta = perm_state_o ^ s_model;
                    blk++;
                    if (lat_pend) begin
                        chk32("word_to_perm_latency", cnt - last_acc, 2);
                        lat_pend = 0;
                    end
                    pr_cd = (pr_delay < 0) ? $urandom_range(0, 3) : pr_delay;
                end
                chk("perm_state", perm_state_o, exp_blk);
                if (pr_cd == 0) begin
                    perm_ready = 1'b1;
                    seen_pv = 0;
                    done_cd = $urandom_range(0, 3);
                end else begin
                    pr_cd--;
                end
            end
            if (!finished && word_ready && wi < nw && (!rnd || $urandom_range(0, 3) != 0)) begin
                word_valid = 1'b1;
                word = wd[wi];
                word_bytes = wb[wi];
                word_last = wl[wi];
                if (wl[wi]) begin
                    last_acc = cnt;
                    lat_pend = 1;
                end
                wi++;
            end else begin
                word = {$urandom, $urandom};
                word_bytes = 4'($urandom);
                word_last = 1'($urandom);
            end
            if (!finished && state_valid) begin
                if (!seen_sv) begin
                    seen_sv = 1;
                    chk32("done_to_state_latency", cnt - done_cyc, 1);
                    chk32("num_blocks", blk, nblk);
                    if (exp_nblk >= 0) chk32("table_blocks", blk, exp_nblk);
`ifdef KECCAK_ABSORB_BLKCNT_EN
                    chk32("blk_cnt", int'(blk_cnt), nblk);
`endif
                    st_cd = (st_delay < 0) ? $urandom_range(0, 2) : st_delay;
                end
                chk("final_state", state_o, s_model);
                if (st_cd == 0) begin
                    state_ready = 1'b1;
                    finished = 1;
                end else begin
                    st_cd--;
                end
            end
        end
        if (!abort && seen_sv) begin
            @(negedge clk);
            state_ready = 1'b0;
            chk32("post_done_valid", int'(state_valid), 0);
            chk("post_done_state", state_o, '0);
            chk32("post_done_ready", int'(word_ready), 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [1599:0] d;
        tbl[0] = '{len: 76,  nblk: 1, pos: 76,  vpos: 8'h01, v135: 8'h80};
        tbl[1] = '{len: 135, nblk: 1, pos: 135, vpos: 8'h81, v135: 8'h81};
        tbl[2] = '{len: 136, nblk: 2, pos: 0,   vpos: 8'h01, v135: 8'h80};
        tbl[3] = '{len: 0,   nblk: 1, pos: 0,   vpos: 8'h01, v135: 8'h80};
        tbl[4] = '{len: 8,   nblk: 1, pos: 8,   vpos: 8'h01, v135: 8'h80};
        tbl[5] = '{len: 271, nblk: 2, pos: 135, vpos: 8'h81, v135: 8'h81};
        tbl[6] = '{len: 272, nblk: 3, pos: 0,   vpos: 8'h01, v135: 8'h80};

        rst_n = 1'b0;
        word = '0; word_bytes = 4'd0; word_last = 1'b0; word_valid = 1'b0;
        perm_ready = 1'b0; perm_state_i = '0; perm_done = 1'b0; state_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk32("reset_word_ready", int'(word_ready), 0);
        chk32("reset_perm_valid", int'(perm_valid), 0);
        chk32("reset_state_valid", int'(state_valid), 0);
        chk("reset_state", state_o, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk32("ready_after_reset", int'(word_ready), 1);

        foreach (tbl[i]) begin
            run_msg(tbl[i].len, 1'b0, -1, -1, 1'b0, tbl[i].nblk, d);
            chk32("pad_byte_pos", int'(d[8*tbl[i].pos +: 8]), int'(tbl[i].vpos));
            chk32("pad_byte_135", int'(d[8*135 +: 8]), int'(tbl[i].v135));
            d[8*tbl[i].pos +: 8] = 8'h00;
            d[8*135 +: 8] = 8'h00;
            chk("pad_rest_zero", d, '0);
        end

        // Backpressure on both handshakes
        run_msg(76, 1'b1, 5, 3, 1'b0, 1, d);

        for (int r = 0; r < 8; r++) run_msg($urandom_range(0, 420), 1'b1, -1, -1, 1'b0, -1, d);

        // Reset while waiting for the permutation, then a stray done strobe
        run_msg(76, 1'b1, 0, 0, 1'b1, -1, d);
        #1;
        chk32("abort_word_ready", int'(word_ready), 0);
        chk32("abort_perm_valid", int'(perm_valid), 0);
        chk32("abort_state_valid", int'(state_valid), 0);
        chk("abort_state", state_o, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        perm_done = 1'b1;
        perm_state_i = {50{$urandom}};
        @(negedge clk);
        perm_done = 1'b0;
        @(negedge clk);
        chk("late_done_state", state_o, '0);
        chk32("late_done_perm_valid", int'(perm_valid), 0);
        chk32("late_done_state_valid", int'(state_valid), 0);
        chk32("late_done_ready", int'(word_ready), 1);
        run_msg(76, 1'b1, -1, -1, 1'b0, 1, d);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
